// File: rtl/instr_fifo_pkg.sv
// Core constants shared by fetch and the instruction queue.
// Fetched words drop bits [1:0]; they are restored as 2'b11.
package instr_fifo_pkg;

  localparam int unsigned INSTR_W = 30;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] LOW_BITS = 2'b11;

  function automatic logic [31:0] restore_instr(
    input logic [INSTR_W-1:0] w
  );
    return {w, LOW_BITS};
  endfunction

endpackage

// File: rtl/instr_fifo_mem.sv
// Instruction queue storage: one write port, one async read port.
// No reset on the array; pointers guard stale contents.
module instr_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 30,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clockGate,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clockGate) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fifo.sv
// Fetch-to-decode instruction queue, first-word fall-through.
// Flush drops all entries so no wrong-path word reaches decode.
module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = instr_fifo_pkg::INSTR_W,
  parameter logic [31:0] NOP     = instr_fifo_pkg::NOP,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1
) (
  input  logic               clockGate,
  input  logic               resetn,
  input  logic               push,
  input  logic [INSTR_W-1:0] instrIn,
  output logic               bufferFull,
  input  logic               flush,
  input  logic               pop,
  output logic               valid,
  output logic [31:0]        instrOut,
  output logic [CW-1:0]      count
);

  logic [AW-1:0]      wp_q, wp_d;
  logic [AW-1:0]      rp_q, rp_d;
  logic [CW-1:0]      count_q, count_d;
  logic               wr, rd;
  logic [INSTR_W-1:0] head;

  // Flags come from the registered count only.
  assign bufferFull = (count_q == CW'(DEPTH));
  assign valid      = (count_q != '0);
  assign count      = count_q;

  assign wr = push & ~bufferFull & ~flush;
  assign rd = pop & valid & ~flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    unique case (1'b1)
      flush: begin
        wp_d    = '0;
        rp_d    = '0;
        count_d = '0;
      end
      default: begin
        if (wr) wp_d = wp_q + AW'(1);
        if (rd) rp_d = rp_q + AW'(1);
        count_d = count_q + CW'(wr) - CW'(rd);
      end
    endcase
  end

  always_ff @(posedge clockGate or negedge resetn) begin
    if (!resetn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  instr_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_mem (
    .clockGate (clockGate),
    .we_i      (wr),
    .waddr_i   (wp_q),
    .wdata_i   (instrIn),
    .raddr_i   (rp_q),
    .rdata_o   (head)
  );

  assign instrOut = valid ? {head, LOW_BITS} : NOP;

endmodule

// File: doc/instr_fifo.md
# instr_fifo

Instruction queue between the fetch stage and the decode stage. Accepts 30-bit compressed-encoding-free instruction words (bits [31:2]) pushed by fetch, asserts `bufferFull` back to fetch, and presents restored 32-bit instructions to decode through a valid/pop handshake. Flushed on branch redirect so that no wrong-path instruction reaches decode.

## Interface
Parameters:
- `DEPTH`, 8: entries; power of two, ≥ 2.
- `INSTR_W`, 30: stored instruction width (instruction bits [31:2]).
- `NOP`, 32'h00000013: word presented on `instrOut` when empty.

Ports:
- `clockGate`  in  1  block clock; rising edge. At integration it is driven from the ungated core clock, never from fetch's gated clock, because fetch's gate stops while `bufferFull`=1 and the pop side must keep running.
- `resetn`  in  1  asynchronous, active-low reset.
- `push`  in  1  fetch writes `instrIn` this cycle.
- `instrIn`  in  INSTR_W  instruction bits [31:2].
- `bufferFull`  out  1  no free entry; fetch must not push.
- `flush`  in  1  discard all contents (redirect/interrupt).
- `pop`  in  1  decode consumes the head entry this cycle.
- `valid`  out  1  head entry present.
- `instrOut`  out  32  `{head, 2'b11}` when `valid`, else `NOP`.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Storage: DEPTH x INSTR_W array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH. Occupancy counter `count` 0..DEPTH.
- Effective write `wr = push & ~bufferFull & ~flush`; effective read `rd = pop & valid & ~flush`.
- `wr`: mem[wp] <= instrIn, wp <= wp+1. `rd`: rp <= rp+1.
- count <= count + wr − rd; simultaneous wr and rd leave count unchanged.
- `flush`: wp, rp, count <= 0 next edge; has priority over push and pop in the same cycle (that cycle's push is dropped, pop is not counted). Array contents need not be cleared.
- `valid` = (count != 0); `bufferFull` = (count == DEPTH); both decoded from registered count, no combinational path from `push`/`pop`.
- Push while full: ignored, no pointer or count change (protocol violation by fetch; bench checks that fetch never does it).
- Pop while empty: ignored.
- Full and pop in same cycle: push is still refused that cycle (bufferFull registered); the freed slot is visible as `bufferFull`=0 next cycle.
- Empty and push+pop same cycle: only the write takes effect.
- Output is first-word fall-through: `instrOut` is a combinational read of mem[rp] with bits [1:0] forced to 2'b11.

## Timing
- Reset (asynchronous, mid-operation included): wp=rp=count=0, `valid`=0, `bufferFull`=0, `instrOut`=NOP, `count`=0. Release takes effect on the next rising edge.
- Push-to-visible latency: 1 cycle (push at edge N, `valid`=1 and data on `instrOut` after edge N).
- Pop: head advances at the edge where `pop & valid`; next entry visible immediately after that edge.
- Flush: `valid`=0, `bufferFull`=0 after the edge at which `flush`=1 is sampled.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Shared core package: `NOP` constant, `INSTR_W`, and the `2'b11` low-bits constant used for restoring fetched words (also used by fetch).
- One natural sub-module: `instr_fifo_mem`, a 1-write/1-async-read register array (DEPTH x INSTR_W). Pointer, count and flag logic stay in `instr_fifo`.

## Test plan
- Reset then idle: `valid`=0, `bufferFull`=0, `count`=0, `instrOut`=32'h00000013.
- Push 30'h0000_0004 (ADDI x0... word 32'h00000013>>2 excluded) and 30'h00A0_0024 on consecutive cycles, then pop twice -> `instrOut`=32'h00000013 first then 32'h0280_0093, `count` 1,2,1,0.
- Push 8 words with DEPTH=8 -> `bufferFull`=1 after 8th edge, 9th push ignored (`count` stays 8); one pop -> `bufferFull`=0 next cycle.
- Fill to 5, push+pop simultaneously for 20 cycles with incrementing data -> `count` stays 5, data order preserved across pointer wrap.
- Fill to 6, assert `flush` together with `push` and `pop` -> next cycle `count`=0, `valid`=0, pushed word never appears.
- Assert `resetn`=0 asynchronously with 3 entries queued, mid-cycle -> outputs return to reset values immediately without a clock edge.
